// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
//   Write-side front end for the register file. Merges the single-cycle ALU
//   result stream and a long-latency (load / mul-div) result stream into the
//   register file's single write port. Long-latency results are buffered in a
//   small FIFO. A per-register scoreboard tracks destinations that are still
//   awaiting a long-latency result.
//
// Ports
//   elk        clock, rising edge
//   nrst       synchronous, active-high reset
//   alu_*      ALU result (valid/addr/data); alu_stall asks upstream to idle
//   lu_*       long-latency result handshake (valid/ready/addr/data)
//   iss_*      long-latency issue; marks destination pending
//   pending    scoreboard, bit n = register n awaiting long-latency result
//   lq_count   queue occupancy
//   wr_*       registered register-file write port
//   proto_err  sticky: alu_valid observed while alu_stall was high
// -----------------------------------------------------------------------------
module regfile_writeback #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int LQ_DEPTH   = 2,
    parameter int STARVE_MAX = 4,
    localparam int NREG  = 2 ** ADDR_W,
    localparam int CNT_W = $clog2(LQ_DEPTH + 1),
    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1,
    localparam int ST_W  = $clog2(STARVE_MAX + 1)
) (
    input  logic              elk,
    input  logic              nrst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_stall,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [NREG-1:0]   pending,
    output logic [CNT_W-1:0]  lq_count,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              proto_err
);

    // Queue storage
    logic [ADDR_W-1:0] lq_addr_mem [LQ_DEPTH];
    logic [DATA_W-1:0] lq_data_mem [LQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic [ST_W-1:0]   starve_reg, starve_next;
    logic [NREG-1:0]   pending_reg, pending_next;
    logic              wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [DATA_W-1:0] wr_data_reg, wr_data_next;
    logic              proto_err_reg;

    logic              not_empty, push, pop, alu_win;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign not_empty = (count_reg != '0);
    // Readiness comes from the registered count only, so a same-cycle pop
    // never makes room for a push into a full queue.
    assign lu_ready  = (count_reg < CNT_W'(LQ_DEPTH)) & ~nrst;
    assign alu_stall = (starve_reg == ST_W'(STARVE_MAX)) & not_empty & ~nrst;
    assign push      = lu_valid & lu_ready;
    assign alu_win   = alu_valid & ~alu_stall;
    assign pop       = not_empty & ~alu_win;
    assign head_addr = lq_addr_mem[rd_ptr_reg];
    assign head_data = lq_data_mem[rd_ptr_reg];

    // Write-port selection. Address 0 consumes the slot but never writes.
    always_comb begin
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        if (alu_win) begin
            wr_en_next = (alu_addr != '0);
            if (alu_addr != '0) begin
                wr_addr_next = alu_addr;
                wr_data_next = alu_data;
            end
        end else if (pop) begin
            wr_en_next = (head_addr != '0);
            if (head_addr != '0) begin
                wr_addr_next = head_addr;
                wr_data_next = head_data;
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Starvation counter counts ALU wins while long-latency work waits.
    always_comb begin
        starve_next = starve_reg;
        if (pop || !not_empty)
            starve_next = '0;
        else if (alu_win && starve_reg != ST_W'(STARVE_MAX))
            starve_next = starve_reg + ST_W'(1);
    end

    // Scoreboard: issue set wins over pop clear; register 0 is never pending.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_reg
                assign pending_next[gi] =
                    (iss_valid && iss_addr == ADDR_W'(gi)) ||
                    (pending_reg[gi] && !(pop && head_addr == ADDR_W'(gi)));
            end
        end
    endgenerate

    always_ff @(posedge elk) begin
        if (push) begin
            lq_addr_mem[wr_ptr_reg] <= lu_addr;
            lq_data_mem[wr_ptr_reg] <= lu_data;
        end
    end

    always_ff @(posedge elk) begin
        if (nrst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            starve_reg    <= '0;
            pending_reg   <= '0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            count_reg     <= count_next;
            starve_reg    <= starve_next;
            pending_reg   <= pending_next;
            wr_en_reg     <= wr_en_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            if (alu_valid && alu_stall) proto_err_reg <= 1'b1;
        end
    end

    assign pending   = pending_reg;
    assign lq_count  = count_reg;
    assign wr_en     = wr_en_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_regfile_writeback.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback
//   Directed bench for regfile_writeback: one task per scenario, each with
//   hand-computed expected values. Inputs change 1 time unit after the rising
//   edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_regfile_writeback;

    logic        elk = 1'b0;
    logic        nrst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        alu_stall;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_addr = '0;
    logic [31:0] lu_data = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic [31:0] pending;
    logic [1:0]  lq_count;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        proto_err;

    int checks = 0;
    int failures = 0;

    regfile_writeback dut (
        .elk(elk), .nrst(nrst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .alu_stall(alu_stall),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .pending(pending), .lq_count(lq_count),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .proto_err(proto_err)
    );

    always #5 elk = ~elk;

    task automatic tick();
        @(posedge elk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b1;
        tick();
        tick();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%0b exp=0", wr_en); end
        checks++; if (wr_addr !== 5'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
        checks++; if (wr_data !== 32'h0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
        checks++; if (pending !== 32'h0) begin failures++; $display("FAIL reset_pending got=%h exp=0", pending); end
        checks++; if (lq_count !== 2'd0) begin failures++; $display("FAIL reset_lq_count got=%0d exp=0", lq_count); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto_err got=%0b exp=0", proto_err); end
        checks++; if (lu_ready !== 1'b0) begin failures++; $display("FAIL reset_lu_ready got=%0b exp=0", lu_ready); end
        checks++; if (alu_stall !== 1'b0) begin failures++; $display("FAIL reset_alu_stall got=%0b exp=0", alu_stall); end
        nrst = 1'b0;
        #1;
        checks++; if (lu_ready !== 1'b1) begin failures++; $display("FAIL release_lu_ready got=%0b exp=1", lu_ready); end
        $display("reset: done");
    endtask

    task automatic test_alu_write();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL alu_wr_en got=%0b exp=1", wr_en); end
        checks++; if (wr_addr !== 5'd5) begin failures++; $display("FAIL alu_wr_addr got=%0d exp=5", wr_addr); end
        checks++; if (wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_wr_data got=%h exp=deadbeef", wr_data); end
        tick();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL alu_idle_wr_en got=%0b exp=0", wr_en); end
        checks++; if (wr_addr !== 5'd5) begin failures++; $display("FAIL alu_hold_wr_addr got=%0d exp=5", wr_addr); end
        $display("alu_write: addr=5 data=deadbeef");
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            alu_valid = 1'b1; alu_addr = 5'(i); alu_data = 32'h1000 + 32'(i);
            tick();
            checks++; if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== 32'h1000 + 32'(i)) begin
                failures++;
                $display("FAIL b2b_write%0d got en=%0b addr=%0d data=%h exp en=1 addr=%0d data=%h",
                         i, wr_en, wr_addr, wr_data, i, 32'h1000 + 32'(i));
            end
        end
        alu_valid = 1'b0;
        tick();
        $display("back_to_back: 3 writes");
    endtask

    task automatic test_long_latency();
        iss_valid = 1'b1; iss_addr = 5'd9;
        tick();
        iss_valid = 1'b0;
        checks++; if (pending !== 32'h0000_0200) begin failures++; $display("FAIL ll_pending_set got=%h exp=00000200", pending); end
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h12345678;
        #1;
        checks++; if (lu_ready !== 1'b1) begin failures++; $display("FAIL ll_lu_ready got=%0b exp=1", lu_ready); end
        tick();
        lu_valid = 1'b0;
        checks++; if (lq_count !== 2'd1 || wr_en !== 1'b0) begin failures++; $display("FAIL ll_accept got count=%0d en=%0b exp count=1 en=0", lq_count, wr_en); end
        tick();
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'h12345678) begin
            failures++; $display("FAIL ll_write got en=%0b addr=%0d data=%h exp en=1 addr=9 data=12345678", wr_en, wr_addr, wr_data);
        end
        checks++; if (pending !== 32'h0 || lq_count !== 2'd0) begin failures++; $display("FAIL ll_clear got pend=%h count=%0d exp pend=0 count=0", pending, lq_count); end
        $display("long_latency: addr=9 data=12345678");
    endtask

    task automatic test_starvation();
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hA0;
        lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'h33;
        tick();
        lu_addr = 5'd4; lu_data = 32'h44;
        tick();
        lu_valid = 1'b0;
        checks++; if (lu_ready !== 1'b0 || lq_count !== 2'd2) begin failures++; $display("FAIL starve_full got ready=%0b count=%0d exp ready=0 count=2", lu_ready, lq_count); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (alu_stall !== 1'b0) begin failures++; $display("FAIL starve_early_stall%0d got=%0b exp=0", i, alu_stall); end
            tick();
        end
        checks++; if (alu_stall !== 1'b1) begin failures++; $display("FAIL starve_stall1 got=%0b exp=1", alu_stall); end
        alu_valid = 1'b0;
        tick();
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'h33 || lq_count !== 2'd1) begin
            failures++; $display("FAIL starve_pop3 got en=%0b addr=%0d data=%h count=%0d exp en=1 addr=3 data=33 count=1", wr_en, wr_addr, wr_data, lq_count);
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (alu_stall !== 1'b0) begin failures++; $display("FAIL starve_second_stall%0d got=%0b exp=0", i, alu_stall); end
            alu_valid = 1'b1; alu_data = 32'hB0 + 32'(i);
            tick();
            checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd10 || wr_data !== 32'hB0 + 32'(i)) begin
                failures++; $display("FAIL starve_alu%0d got en=%0b addr=%0d data=%h exp en=1 addr=10 data=%h", i, wr_en, wr_addr, wr_data, 32'hB0 + 32'(i));
            end
        end
        checks++; if (alu_stall !== 1'b1) begin failures++; $display("FAIL starve_stall2 got=%0b exp=1", alu_stall); end
        alu_valid = 1'b0;
        tick();
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd4 || wr_data !== 32'h44 || lq_count !== 2'd0) begin
            failures++; $display("FAIL starve_pop4 got en=%0b addr=%0d data=%h count=%0d exp en=1 addr=4 data=44 count=0", wr_en, wr_addr, wr_data, lq_count);
        end
        $display("starvation: two forced drains");
    endtask

    task automatic test_reg0();
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
        tick();
        alu_valid = 1'b0;
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reg0_alu_wr_en got=%0b exp=0", wr_en); end
        iss_valid = 1'b1; iss_addr = 5'd0;
        lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'h55;
        tick();
        iss_valid = 1'b0; lu_valid = 1'b0;
        checks++; if (pending !== 32'h0 || lq_count !== 2'd1) begin failures++; $display("FAIL reg0_queued got pend=%h count=%0d exp pend=0 count=1", pending, lq_count); end
        tick();
        checks++; if (wr_en !== 1'b0 || lq_count !== 2'd0 || pending !== 32'h0) begin
            failures++; $display("FAIL reg0_pop got en=%0b count=%0d pend=%h exp en=0 count=0 pend=0", wr_en, lq_count, pending);
        end
        $display("reg0: writes suppressed");
    endtask

    task automatic test_set_wins();
        iss_valid = 1'b1; iss_addr = 5'd7;
        tick();
        iss_valid = 1'b0;
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h77;
        tick();
        lu_valid = 1'b0;
        checks++; if (lq_count !== 2'd1 || pending !== 32'h80) begin failures++; $display("FAIL setwin_queued got count=%0d pend=%h exp count=1 pend=80", lq_count, pending); end
        iss_valid = 1'b1; iss_addr = 5'd7;
        tick();
        iss_valid = 1'b0;
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h77) begin
            failures++; $display("FAIL setwin_write got en=%0b addr=%0d data=%h exp en=1 addr=7 data=77", wr_en, wr_addr, wr_data);
        end
        checks++; if (pending !== 32'h80) begin failures++; $display("FAIL setwin_pending got=%h exp=00000080", pending); end
        $display("set_wins: pending[7] kept");
    endtask

    task automatic test_proto_err_reset();
        alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'hCAFE0000;
        lu_valid = 1'b1; lu_addr = 5'd11; lu_data = 32'hB1;
        tick();
        lu_addr = 5'd12; lu_data = 32'hB2;
        tick();
        lu_valid = 1'b0;
        checks++; if (lq_count !== 2'd2) begin failures++; $display("FAIL perr_fill got=%0d exp=2", lq_count); end
        for (int i = 0; i < 8 && alu_stall !== 1'b1; i++) tick();
        checks++; if (alu_stall !== 1'b1) begin failures++; $display("FAIL perr_stall_timeout got=%0b exp=1", alu_stall); end
        alu_data = 32'h00000BAD;
        tick();
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd11 || wr_data !== 32'hB1 || lq_count !== 2'd1) begin
            failures++; $display("FAIL perr_write got en=%0b addr=%0d data=%h count=%0d exp en=1 addr=11 data=b1 count=1", wr_en, wr_addr, wr_data, lq_count);
        end
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL perr_set got=%0b exp=1", proto_err); end
        alu_data = 32'hC0;
        lu_valid = 1'b1; lu_addr = 5'd13; lu_data = 32'hB3;
        tick();
        lu_valid = 1'b0; alu_valid = 1'b0;
        checks++; if (lq_count !== 2'd2 || proto_err !== 1'b1 || wr_addr !== 5'd20) begin
            failures++; $display("FAIL perr_refill got count=%0d perr=%0b addr=%0d exp count=2 perr=1 addr=20", lq_count, proto_err, wr_addr);
        end
        nrst = 1'b1;
        tick();
        checks++; if (lq_count !== 2'd0 || wr_en !== 1'b0 || pending !== 32'h0 || proto_err !== 1'b0) begin
            failures++; $display("FAIL midreset got count=%0d en=%0b pend=%h perr=%0b exp all 0", lq_count, wr_en, pending, proto_err);
        end
        checks++; if (lu_ready !== 1'b0 || alu_stall !== 1'b0) begin failures++; $display("FAIL midreset_hs got ready=%0b stall=%0b exp 0 0", lu_ready, alu_stall); end
        nrst = 1'b0;
        tick();
        checks++; if (wr_en !== 1'b0 || lq_count !== 2'd0) begin failures++; $display("FAIL postreset got en=%0b count=%0d exp 0 0", wr_en, lq_count); end
        $display("proto_err_reset: sticky error and flush");
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_back_to_back();
        test_long_latency();
        test_starvation();
        test_reg0();
        test_set_wins();
        test_proto_err_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
